display_7seg_scan: RTL and testbench
====================================

DISPLAY_7SEG_SCAN -- requirements
Module: display_7seg_scan

Interface
REQ-001 The module SHALL provide parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 The module SHALL provide parameter SCAN_DIV, default 50000: clock cycles per digit slot, legal range >= 2.
REQ-003 The module SHALL provide parameter SEG_ACTIVE_LOW, default 1: 1 = segment lit by 0, 0 = lit by 1.
REQ-004 The module SHALL provide parameter AN_ACTIVE_LOW, default 1: 1 = anode enabled by 0, 0 = enabled by 1.
REQ-005 The module SHALL have port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The module SHALL have port load, input, 1 bit: capture value/dp_in into shadow registers.
REQ-008 The module SHALL have port value, input, 4*NUM_DIGITS bits: hex nibbles, nibble i = digit i, digit 0 least significant.
REQ-009 The module SHALL have port dp_in, input, NUM_DIGITS bits: decimal point request per digit.
REQ-010 The module SHALL have port blank_lz, input, 1 bit: leading-zero suppression enable.
REQ-011 The module SHALL have port enable, input, 1 bit: display on; 0 blanks output and freezes scan.
REQ-012 The module SHALL have port seg, output, 7 bits: segments, bit 6..0 = g,f,e,d,c,b,a.
REQ-013 The module SHALL have port dp, output, 1 bit: decimal point segment, same polarity as seg.
REQ-014 The module SHALL have port an, output, NUM_DIGITS bits: one-hot digit anode enables.
REQ-015 The module SHALL have port scan_tick, output, 1 bit: one-cycle pulse at each digit advance.

Function
REQ-016 Shadow registers SHALL load value and dp_in on a rising edge with load=1; otherwise they SHALL hold.
REQ-017 Prescaler SHALL count 0..SCAN_DIV-1 while enable=1, wrap to 0, and hold its value while enable=0.
REQ-018 scan_tick SHALL be registered and SHALL be 1 for exactly the cycle following prescaler = SCAN_DIV-1 with enable=1.
REQ-019 The digit index SHALL advance on the same edge scan_tick is set, wrapping from NUM_DIGITS-1 to 0; when NUM_DIGITS=1 it SHALL stay 0.
REQ-020 seg, dp and an SHALL be registered from current index and shadow, so changes appear one cycle after an index or shadow update.
REQ-021 Active-low segment codes for 0..F SHALL be: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-022 With SEG_ACTIVE_LOW=0, seg and dp SHALL be the bitwise inverse of the active-low form; with AN_ACTIVE_LOW=0, an SHALL likewise be inverted.
REQ-023 The selected digit's anode SHALL be active, all others inactive; dp SHALL be lit iff the shadow dp bit of the selected digit is 1.
REQ-024 With blank_lz=1, digit i>0 SHALL be blanked when nibbles NUM_DIGITS-1 down to i are all zero; digit 0 SHALL never be suppressed.
REQ-025 A blanked digit SHALL keep its anode active, with all segments and dp off.
REQ-026 With enable=0, all anodes and segments SHALL be inactive from the next edge, and scan_tick SHALL be 0.
REQ-027 When enable rises, scanning SHALL resume from the held index and prescaler.
REQ-028 If load and prescaler wrap occur on the same edge, the next digit SHALL display the newly loaded shadow data.

Reset
REQ-029 While rst_n=0, shadow, prescaler, index and scan_tick SHALL be 0, and seg, dp and an SHALL be inactive per polarity parameters.
REQ-030 Assertion of rst_n mid-scan SHALL take effect immediately and asynchronously; after release, the first scan_tick SHALL occur SCAN_DIV cycles later.

Verification
REQ-031 Defaults, SCAN_DIV=4, load value=16'h12AF, dp_in=0 -> an cycles 1110,1101,1011,0111 every 4 cycles; seg = 0001110, 0001000, 0100100, 1111001.
REQ-032 blank_lz=1, value=16'h0050 -> digits 3 and 2 blanked (seg=1111111), digit 1 = 0010010, digit 0 = 1000000.
REQ-033 value=16'h0000, blank_lz=1 -> only digit 0 lit, showing 1000000; dp_in=4'b0001 -> dp=0 only while an=1110.
REQ-034 enable=0 for 10 cycles mid-slot -> an=1111, seg=1111111, no scan_tick, prescaler held; re-enable resumes same digit.
REQ-035 load on the wrap edge -> the next digit shows new data; rst_n pulse mid-scan -> outputs inactive immediately, index 0.
REQ-036 SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0, NUM_DIGITS=1, value=4'h8 -> an=1, seg=1111111, scan_tick every SCAN_DIV cycles.

Source files
------------

// File: rtl/display_7seg_scan.sv
// Multiplexed hex 7-segment display driver: shadowed value/dp registers,
// prescaled digit scan, leading-zero blanking and registered outputs.
module display_7seg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    scan_tick
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW    = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]    PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  // XOR masks turning the internal active-low form into the pin polarity
  localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
  localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic [NUM_DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? '0 : '1;

  logic [4*NUM_DIGITS-1:0] r_val;
  logic [NUM_DIGITS-1:0]   r_dps;
  logic [PW-1:0]           r_pre;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_tick;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic                    w_dp_sel;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic [6:0]              w_seg_lo;
  logic                    w_dp_lo;

  function automatic logic [6:0] f_seg_lo(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign w_wrap = enable && (r_pre == PRE_LAST);

  // Walk from the top digit down so the "all zero from here up" flag is
  // available when the selected digit is reached.
  always_comb begin
    logic v_zero;
    v_zero   = 1'b1;
    w_nib    = 4'h0;
    w_dp_sel = 1'b0;
    w_blank  = 1'b0;
    w_sel    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_zero = v_zero && (r_val[4*i +: 4] == 4'h0);
      if (r_idx == IDX_W'(i)) begin
        w_nib    = r_val[4*i +: 4];
        w_dp_sel = r_dps[i];
        w_sel[i] = 1'b1;
        w_blank  = blank_lz && (i != 0) && v_zero;
      end
    end
  end

  assign w_seg_lo = w_blank ? 7'h7F : f_seg_lo(w_nib);
  assign w_dp_lo  = ~(w_dp_sel & ~w_blank);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= '0;
      r_dps <= '0;
    end else if (load) begin
      r_val <= value;
      r_dps <= dp_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_idx  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (enable) r_pre <= w_wrap ? '0 : r_pre + 1'b1;
      if (w_wrap) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= 7'h7F ^ SEG_INV;
      r_dp  <= 1'b1 ^ DP_INV;
      r_an  <= '1 ^ AN_INV;
    end else if (enable) begin
      r_seg <= w_seg_lo ^ SEG_INV;
      r_dp  <= w_dp_lo ^ DP_INV;
      r_an  <= ~w_sel ^ AN_INV;
    end else begin
      r_seg <= 7'h7F ^ SEG_INV;
      r_dp  <= 1'b1 ^ DP_INV;
      r_an  <= '1 ^ AN_INV;
    end
  end

  assign seg       = r_seg;
  assign dp        = r_dp;
  assign an        = r_an;
  assign scan_tick = r_tick;
endmodule

// File: tb/tb_display_7seg_scan.sv
// Bench for display_7seg_scan: per-cycle reference model plus directed
// literal checks on a 4-digit active-low and a 1-digit active-high instance.
module tb_display_7seg_scan;
  logic        clk = 1'b0;
  logic        rst_n, load, blank_lz, enable;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp, tick;
  logic [3:0]  an;
  logic [6:0]  seg1;
  logic        dp1, tick1;
  logic [0:0]  an1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  display_7seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4)) u0 (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .enable(enable), .seg(seg), .dp(dp), .an(an),
    .scan_tick(tick));

  display_7seg_scan #(.NUM_DIGITS(1), .SCAN_DIV(4), .SEG_ACTIVE_LOW(0),
                      .AN_ACTIVE_LOW(0)) u1 (
    .clk(clk), .rst_n(rst_n), .load(1'b1), .value(4'h8), .dp_in(1'b0),
    .blank_lz(1'b0), .enable(1'b1), .seg(seg1), .dp(dp1), .an(an1),
    .scan_tick(tick1));

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: active-low segment patterns straight from the code table
  logic [6:0] SEG_TAB [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  function automatic logic f_blank(input logic [15:0] v, input int d, input logic blz);
    return blz && (d > 0) && ((v >> (4*d)) == 16'h0);
  endfunction

  function automatic logic [6:0] f_seg(input logic [15:0] v, input int d, input logic blz);
    logic [3:0] nib;
    nib = 4'((v >> (4*d)) & 16'hF);
    return f_blank(v, d, blz) ? 7'h7F : SEG_TAB[nib];
  endfunction

  function automatic logic f_dp(input logic [15:0] v, input logic [3:0] dps, input int d, input logic blz);
    return !(dps[d] && !f_blank(v, d, blz));
  endfunction

  logic [15:0] m_val = '0;
  logic [3:0]  m_dps = '0;
  int          m_ph = 0;
  int          m_dig = 0;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic [3:0]  e_an = 4'hF;
  logic        e_tick = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val <= '0; m_dps <= '0; m_ph <= 0; m_dig <= 0;
      e_seg <= 7'h7F; e_dp <= 1'b1; e_an <= 4'hF; e_tick <= 1'b0;
    end else begin
      if (load) begin
        m_val <= value;
        m_dps <= dp_in;
      end
      if (enable) begin
        e_an   <= ~(4'b0001 << m_dig);
        e_seg  <= f_seg(m_val, m_dig, blank_lz);
        e_dp   <= f_dp(m_val, m_dps, m_dig, blank_lz);
        e_tick <= (m_ph == 3);
        m_ph   <= (m_ph + 1) % 4;
        if (m_ph == 3) m_dig <= (m_dig + 1) % 4;
      end else begin
        e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1; e_tick <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_seg", {9'h0, seg}, {9'h0, e_seg});
    chk("model_an", {12'h0, an}, {12'h0, e_an});
    chk("model_dp", {15'h0, dp}, {15'h0, e_dp});
    chk("model_tick", {15'h0, tick}, {15'h0, e_tick});
  end

  task automatic wait_an(input string nm, input logic [3:0] a, input logic [6:0] s, input logic d);
    int k;
    k = 0;
    while (an !== a && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_an"}, {12'h0, an}, {12'h0, a});
    chk({nm, "_seg"}, {9'h0, seg}, {9'h0, s});
    chk({nm, "_dp"}, {15'h0, dp}, {15'h0, d});
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    logic [3:0] saved_an;
    logic [6:0] nseg [4];
    logic [3:0] nan [4];
    int nd, k;
    nseg = '{7'b1111001, 7'b0100100, 7'b0011001, 7'b0000000};
    nan  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_seg", {9'h0, seg}, 16'h007F);
    chk("rst_dp", {15'h0, dp}, 16'h0001);
    chk("rst_tick", {15'h0, tick}, 16'h0000);
    chk("rst_an1", {15'h0, an1}, 16'h0000);
    chk("rst_seg1", {9'h0, seg1}, 16'h0000);
    rst_n = 1'b1;

    load_val(16'h12AF, 4'b0000);
    wait_an("v12AF_d0", 4'b1110, 7'b0001110, 1'b1);
    wait_an("v12AF_d1", 4'b1101, 7'b0001000, 1'b1);
    wait_an("v12AF_d2", 4'b1011, 7'b0100100, 1'b1);
    wait_an("v12AF_d3", 4'b0111, 7'b1111001, 1'b1);

    blank_lz = 1'b1;
    load_val(16'h0050, 4'b0000);
    wait_an("lz_d3", 4'b0111, 7'b1111111, 1'b1);
    wait_an("lz_d2", 4'b1011, 7'b1111111, 1'b1);
    wait_an("lz_d1", 4'b1101, 7'b0010010, 1'b1);
    wait_an("lz_d0", 4'b1110, 7'b1000000, 1'b1);

    load_val(16'h0000, 4'b0001);
    wait_an("zero_d3", 4'b0111, 7'b1111111, 1'b1);
    wait_an("zero_d0", 4'b1110, 7'b1000000, 1'b0);
    wait_an("zero_d1", 4'b1101, 7'b1111111, 1'b1);

    // disable mid-slot, then resume on the same digit
    k = 0;
    while (tick !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk("tick_seen", {15'h0, tick}, 16'h0001);
    @(negedge clk);
    saved_an = an;
    enable = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("dis_an", {12'h0, an}, 16'h000F);
      chk("dis_seg", {9'h0, seg}, 16'h007F);
      chk("dis_tick", {15'h0, tick}, 16'h0000);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("resume_an", {12'h0, an}, {12'h0, saved_an});

    // load coinciding with prescaler wrap
    blank_lz = 1'b0;
    k = 0;
    while (m_ph != 3 && k < 20) begin @(negedge clk); k++; end
    nd = (m_dig + 1) % 4;
    value = 16'h8421; dp_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("wrapload_an", {12'h0, an}, {12'h0, nan[nd]});
    chk("wrapload_seg", {9'h0, seg}, {9'h0, nseg[nd]});

    // asynchronous reset mid-cycle
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_an", {12'h0, an}, 16'h000F);
    chk("arst_seg", {9'h0, seg}, 16'h007F);
    chk("arst_dp", {15'h0, dp}, 16'h0001);
    chk("arst_an1", {15'h0, an1}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("post_rst_an", {12'h0, an}, 16'h000E);
      if (tick === 1'b1) break;
    end
    chk("first_tick_cycles", 16'(k), 16'd4);

    // single-digit active-high instance
    repeat (3) @(negedge clk);
    chk("n1_an", {15'h0, an1}, 16'h0001);
    chk("n1_seg", {9'h0, seg1}, 16'h007F);
    chk("n1_dp", {15'h0, dp1}, 16'h0000);
    k = 0;
    while (tick1 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk("n1_tick_seen", {15'h0, tick1}, 16'h0001);
    k = 0;
    do begin @(negedge clk); k++; end while (tick1 !== 1'b1 && k < 20);
    chk("n1_tick_period", 16'(k), 16'd4);
    chk("n1_an_after", {15'h0, an1}, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
